// File: rtl/shift_unit_seq.sv
// Sequential shift engine: parallel-load a word, then shift/rotate one bit per clock
// for a programmed number of steps, with busy/done handshake.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [AMT_W-1:0] remaining;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] step_data;
  logic             step_ser;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (amount != '0) ? SHIFT : DONE;
      SHIFT:   if (remaining == AMT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // One 1-bit step of the latched mode; the reserved mode leaves everything untouched.
  always_comb begin
    step_data = data_out;
    step_ser  = ser_out;
    case (mode_q)
      3'b000: begin step_data = {data_out[WIDTH-2:0], 1'b0};             step_ser = data_out[WIDTH-1]; end
      3'b001: begin step_data = {1'b0, data_out[WIDTH-1:1]};             step_ser = data_out[0];       end
      3'b010: begin step_data = {data_out[WIDTH-1], data_out[WIDTH-1:1]}; step_ser = data_out[0];       end
      3'b011: begin step_data = {data_out[WIDTH-2:0], data_out[WIDTH-1]}; step_ser = data_out[WIDTH-1]; end
      3'b100: begin step_data = {data_out[0], data_out[WIDTH-1:1]};       step_ser = data_out[0];       end
      3'b101: begin step_data = {data_out[WIDTH-2:0], ser_in};            step_ser = data_out[WIDTH-1]; end
      3'b110: begin step_data = {ser_in, data_out[WIDTH-1:1]};            step_ser = data_out[0];       end
      default: begin step_data = data_out;                                step_ser = ser_out;           end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      ser_out   <= 1'b0;
      remaining <= '0;
      mode_q    <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_out  <= load_data;
            mode_q    <= mode;
            remaining <= amount;
          end
        end
        SHIFT: begin
          data_out  <= step_data;
          ser_out   <= step_ser;
          remaining <= remaining - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
